// File: rtl/deinterleaver_if.sv
// ----------------------------------------------------------------------------
// deinterleaver_if
//   AXI4-Stream bundle used on both sides of the 802.11a/g bit deinterleaver.
//   tdata  : coded / deinterleaved bits, tdata[0] earliest in time
//   tuser  : 4-bit RATE code of the OFDM symbol
//   tvalid : beat valid (master -> slave)
//   tready : beat ready (slave -> master)
//   tlast  : last byte of the frame
// ----------------------------------------------------------------------------
interface deinterleaver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdata;
  logic [3:0]       tuser;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/deinterleaver.sv
// ----------------------------------------------------------------------------
// deinterleaver
//   Receive-side inverse of the IEEE 802.11a/g OFDM bit interleaver. One OFDM
//   symbol of coded bits (N_CBPS bits, byte packed, bit 0 first) is written
//   into one bank of a two-bank bit memory; the other bank is read out in
//   original (pre-interleaving) bit order.
//
//   Ports
//     aclk    : clock, rising edge
//     areset  : synchronous active-high reset
//     s_axis  : slave stream from the demapper (tuser = RATE, sampled on the
//               first byte of each symbol)
//     m_axis  : master stream to the Viterbi decoder (tuser = symbol RATE,
//               tlast on the final byte of a symbol that closed the frame)
// ----------------------------------------------------------------------------
module deinterleaver #(
  parameter int WIDTH = 8
) (
  input  logic              aclk,
  input  logic              areset,
  deinterleaver_if.slave    s_axis,
  deinterleaver_if.master   m_axis
);

  // 802.11a SIGNAL-field RATE codes
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int NBITS = 288;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Modulation class: 0 = BPSK (48 bits), 1 = QPSK (96), 2 = 16QAM (192),
  // 3 = 64QAM (288). Unknown codes fall back to BPSK.
  function automatic logic [1:0] rate_class(input logic [3:0] code);
    case (code)
      RATE_6M, RATE_9M:   rate_class = 2'd0;
      RATE_12M, RATE_18M: rate_class = 2'd1;
      RATE_24M, RATE_36M: rate_class = 2'd2;
      RATE_48M, RATE_54M: rate_class = 2'd3;
      default:            rate_class = 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] sym_bytes(input logic [1:0] cls);
    case (cls)
      2'd0:    sym_bytes = 6'd6;
      2'd1:    sym_bytes = 6'd12;
      2'd2:    sym_bytes = 6'd24;
      default: sym_bytes = 6'd36;
    endcase
  endfunction

  // Source bit j (interleaved position) of output bit k.
  // With c = N_CBPS/16, i = c*(k%16) + k/16 and k/16 < c, so
  // floor(16*i/N_CBPS) collapses to k%16. The N_CBPS term of the column
  // rotation vanishes modulo s (N even for s=2; 288 = 0 mod 3, and 48 is
  // used as a non-negative offset for s=3).
  function automatic logic [8:0] src_index(input logic [1:0] cls, input logic [8:0] k);
    logic [8:0] km;
    logic [8:0] kd;
    logic [8:0] i;
    logic [8:0] q;
    logic [8:0] r;
    km = {5'd0, k[3:0]};
    kd = {4'd0, k[8:4]};
    i  = '0;
    q  = '0;
    r  = '0;
    src_index = '0;
    case (cls)
      2'd0: begin
        i = km * 9'd3 + kd;
        src_index = i;
      end
      2'd1: begin
        i = km * 9'd6 + kd;
        src_index = i;
      end
      2'd2: begin
        i = km * 9'd12 + kd;
        src_index = {i[8:1], i[0] ^ k[0]};
      end
      default: begin
        i = km * 9'd18 + kd;
        q = i / 9'd3;
        r = (i + 9'd48 - km) % 9'd3;
        src_index = q * 9'd3 + r;
      end
    endcase
  endfunction

  // One output byte of a bank; bits beyond what was written for a short
  // (tlast-terminated) symbol read as zero.
  function automatic logic [7:0] gather_byte(input logic [NBITS-1:0] bank,
                                             input logic [1:0]       cls,
                                             input logic [5:0]       nwritten,
                                             input logic [5:0]       byte_idx);
    logic [8:0] j;
    gather_byte = '0;
    for (int t = 0; t < 8; t++) begin
      j = src_index(cls, {byte_idx, t[2:0]});
      if (j < {nwritten, 3'b000}) gather_byte[t] = bank[j];
    end
  endfunction

  // Bank storage (data, not reset)
  logic [NBITS-1:0] mem_q  [2];
  logic [3:0]       rate_q [2];
  logic [5:0]       cnt_q  [2];
  logic [1:0]       last_q;

  // Control state
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic       s_tready_q, s_tready_d;
  state_t     state_q, state_d;

  // Output registers
  logic [WIDTH-1:0] m_tdata_q;
  logic [3:0]       m_tuser_q;
  logic             m_tlast_q;

  // Handshake / decode
  logic       wr_fire, wr_done;
  logic [3:0] wr_rate;
  logic [5:0] rd_nb;
  logic       rd_fire, rd_last, rd_done;
  logic       m_tvalid;
  logic       load_en;
  logic       load_bank;
  logic [5:0] load_idx;
  logic [1:0] load_cls;
  logic [5:0] load_nb;

  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tuser  = m_tuser_q;
  assign m_axis.tlast  = m_tlast_q;

  // Rate is taken from tuser on the first byte and from the bank latch after.
  assign wr_fire = s_axis.tvalid & s_tready_q;
  assign wr_rate = (wr_idx_q == 6'd0) ? s_axis.tuser : rate_q[wr_ptr_q];
  assign wr_done = wr_fire &
                   (s_axis.tlast | (wr_idx_q == sym_bytes(rate_class(wr_rate)) - 6'd1));

  assign rd_nb   = sym_bytes(rate_class(rate_q[rd_ptr_q]));
  assign rd_fire = m_tvalid & m_axis.tready;
  assign rd_last = (rd_idx_q == rd_nb - 6'd1);
  assign rd_done = rd_fire & rd_last;

  assign load_cls = rate_class(rate_q[load_bank]);
  assign load_nb  = sym_bytes(load_cls);

  // ---- write side: bank fill ----
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q][{wr_idx_q, 3'b000} +: WIDTH] <= s_axis.tdata;
      cnt_q[wr_ptr_q] <= wr_idx_q + 6'd1;
      if (wr_idx_q == 6'd0) rate_q[wr_ptr_q] <= s_axis.tuser;
      if (wr_done)          last_q[wr_ptr_q] <= s_axis.tlast;
    end
  end

  // Pointer / flag next state. Write fills only a non-FULL bank and read
  // frees only a FULL bank, so both updates never touch the same bank.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx_d = wr_idx_q;
    rd_ptr_d = rd_ptr_q;
    rd_idx_d = rd_idx_q;
    if (wr_fire) begin
      if (wr_done) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        wr_idx_d         = 6'd0;
      end else begin
        wr_idx_d = wr_idx_q + 6'd1;
      end
    end
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        rd_idx_d         = 6'd0;
      end else begin
        rd_idx_d = rd_idx_q + 6'd1;
      end
    end
    // Registered ready looks at the post-edge flags so a bank freed on the
    // same edge the other one fills keeps tready high.
    s_tready_d = ~full_d[wr_ptr_d];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_idx_q   <= 6'd0;
      rd_idx_q   <= 6'd0;
      s_tready_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      s_tready_q <= s_tready_d;
    end
  end

  // ---- read FSM: state register ----
  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- read FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (full_q[rd_ptr_q]) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (rd_done) state_d = full_q[~rd_ptr_q] ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- read FSM: outputs ----
  // In SEND the next byte is prefetched on every handshake; on the final
  // byte the first byte of the other bank is loaded if it is already FULL.
  always_comb begin
    m_tvalid  = 1'b0;
    load_en   = 1'b0;
    load_bank = rd_ptr_q;
    load_idx  = 6'd0;
    case (state_q)
      ST_LOAD: load_en = 1'b1;
      ST_SEND: begin
        m_tvalid = 1'b1;
        if (m_axis.tready) begin
          if (!rd_last) begin
            load_en  = 1'b1;
            load_idx = rd_idx_q + 6'd1;
          end else if (full_q[~rd_ptr_q]) begin
            load_en   = 1'b1;
            load_bank = ~rd_ptr_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_tdata_q <= '0;
      m_tuser_q <= 4'd0;
      m_tlast_q <= 1'b0;
    end else if (load_en) begin
      m_tdata_q <= gather_byte(mem_q[load_bank], load_cls, cnt_q[load_bank], load_idx);
      m_tuser_q <= rate_q[load_bank];
      m_tlast_q <= last_q[load_bank] & (load_idx == load_nb - 6'd1);
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
module tb_deinterleaver;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  deinterleaver_if #(.WIDTH(8)) s_if ();
  deinterleaver_if #(.WIDTH(8)) m_if ();

  deinterleaver #(.WIDTH(8)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] user;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] user;
    logic       last;
    logic       eos;
  } in_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  in_t   in_q[$];
  beat_t exp_q[$];
  int    vld_pct = 100;
  int    rdy_pct = 100;
  bit    hold_ready0 = 0;
  bit    s_fired = 0;
  int    acc_count = 0;
  int    last_acc_cyc = -1;
  int    rise_cyc = -1;
  bit    prev_tvalid = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;
  int    out_count = 0;
  int    exp_total = 0;

  logic [3:0] rates [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: N_CBPS from RATE and the standard interleaver mapping.
  function automatic int ncbps_of(input logic [3:0] code);
    case (code)
      4'hD, 4'hF: return 48;
      4'h5, 4'h7: return 96;
      4'h9, 4'hB: return 192;
      4'h1, 4'h3: return 288;
      default:    return 48;
    endcase
  endfunction

  function automatic int jmap(input int n, input int k);
    int s;
    int i;
    s = (n / 48) / 2;
    if (s < 1) s = 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  // Interleave random original bits, queue nsend input bytes, and (optionally)
  // queue the expected deinterleaved output bytes.
  task automatic add_symbol(input logic [3:0] code, input int nsend,
                            input bit tlast_flag, input bit expect_out);
    int n;
    int nb;
    bit orig [288];
    bit inb [288];
    logic [7:0] d;
    in_t   it;
    beat_t bt;
    n  = ncbps_of(code);
    nb = n / 8;
    for (int k = 0; k < 288; k++) begin
      orig[k] = 1'b0;
      inb[k]  = 1'b0;
    end
    for (int k = 0; k < n; k++) orig[k] = 1'($urandom_range(1, 0));
    for (int k = 0; k < n; k++) inb[jmap(n, k)] = orig[k];
    for (int b = 0; b < nsend; b++) begin
      for (int t = 0; t < 8; t++) d[t] = inb[8 * b + t];
      it.data = d;
      it.user = (b == 0) ? code : 4'($urandom);
      it.last = tlast_flag && (b == nsend - 1);
      it.eos  = (b == nsend - 1);
      in_q.push_back(it);
    end
    if (expect_out) begin
      for (int b = 0; b < nb; b++) begin
        for (int t = 0; t < 8; t++)
          d[t] = (jmap(n, 8 * b + t) < 8 * nsend) ? orig[8 * b + t] : 1'b0;
        bt.data = d;
        bt.user = code;
        bt.last = tlast_flag && (b == nb - 1);
        exp_q.push_back(bt);
        exp_total++;
      end
    end
  endtask

  task automatic sample();
    beat_t cur;
    beat_t e;
    cur = {m_if.tdata, m_if.tuser, m_if.tlast};
    s_fired = 0;
    if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
      acc_count++;
      if (in_q[0].eos) last_acc_cyc = cyc;
      void'(in_q.pop_front());
      s_fired = 1;
    end
    if (prev_stall) begin
      check("stall_tvalid", {31'd0, m_if.tvalid}, 32'd1);
      check("stall_hold", {19'd0, cur}, {19'd0, prev_beat});
    end
    if (m_if.tvalid === 1'b1 && !prev_tvalid) rise_cyc = cyc;
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      out_count++;
      check("unexpected_out", {31'd0, exp_q.size() == 0}, 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_beat", {19'd0, cur}, {19'd0, e});
      end
    end
    prev_stall  = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
    prev_beat   = cur;
    prev_tvalid = (m_if.tvalid === 1'b1);
  endtask

  task automatic drive();
    if (!(s_if.tvalid === 1'b1 && !s_fired)) begin
      if (in_q.size() > 0 && $urandom_range(99, 0) < vld_pct) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = in_q[0].data;
        s_if.tuser  = in_q[0].user;
        s_if.tlast  = in_q[0].last;
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'($urandom);
        s_if.tuser  = 4'($urandom);
        s_if.tlast  = 1'b0;
      end
    end
    m_if.tready = hold_ready0 ? 1'b0 : ($urandom_range(99, 0) < rdy_pct);
  endtask

  task automatic cycle();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_remaining", in_q.size() + exp_q.size(), 0);
    for (int i = 0; i < 6; i++) cycle();
  endtask

  initial begin
    rates[0] = 4'hD; rates[1] = 4'hF; rates[2] = 4'h5; rates[3] = 4'h7;
    rates[4] = 4'h9; rates[5] = 4'hB; rates[6] = 4'h1; rates[7] = 4'h3;

    areset      = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'd0;
    s_if.tuser  = 4'd0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset values
    cycle();
    cycle();
    check("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("rst_m_tdata",  {24'd0, m_if.tdata},  32'd0);
    check("rst_m_tuser",  {28'd0, m_if.tuser},  32'd0);
    check("rst_m_tlast",  {31'd0, m_if.tlast},  32'd0);
    areset = 1'b0;
    cycle();
    check("post_rst_s_tready", {31'd0, s_if.tready}, 32'd1);

    // 36M symbol, full-rate streaming, latency from last input handshake
    rise_cyc = -1;
    last_acc_cyc = -1;
    add_symbol(4'hB, 24, 1'b1, 1'b1);
    drain(300);
    check("latency_36m", rise_cyc - last_acc_cyc, 3);

    // All 8 rates, 3 symbols each, plus an unknown code treated as 6M
    for (int r = 0; r < 8; r++)
      for (int s = 0; s < 3; s++)
        add_symbol(rates[r], ncbps_of(rates[r]) / 8, s == 2, 1'b1);
    add_symbol(4'h0, 6, 1'b1, 1'b1);
    drain(3000);

    // Three 54M symbols with the output stalled for 100 cycles
    hold_ready0 = 1;
    m_if.tready = 1'b0;
    acc_count   = 0;
    add_symbol(4'h3, 36, 1'b0, 1'b1);
    add_symbol(4'h3, 36, 1'b0, 1'b1);
    add_symbol(4'h3, 36, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) cycle();
    check("stall_accepted", acc_count, 72);
    check("stall_s_tready", {31'd0, s_if.tready}, 32'd0);
    check("stall_m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    hold_ready0 = 0;
    drain(1000);

    // Short 12M symbol: tlast on byte 5
    add_symbol(4'h5, 6, 1'b1, 1'b1);
    drain(300);

    // Reset after 10 bytes of a 36M symbol, then a fresh symbol
    acc_count = 0;
    add_symbol(4'hB, 10, 1'b0, 1'b0);
    for (int i = 0; i < 50 && acc_count < 10; i++) cycle();
    check("partial_accepted", acc_count, 10);
    areset = 1'b1;
    cycle();
    check("mid_rst_s_tready", {31'd0, s_if.tready}, 32'd0);
    check("mid_rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("mid_rst_m_tdata",  {24'd0, m_if.tdata},  32'd0);
    areset = 1'b0;
    cycle();
    check("mid_post_rst_s_tready", {31'd0, s_if.tready}, 32'd1);
    add_symbol(4'hB, 24, 1'b1, 1'b1);
    drain(300);

    // 20 mixed-rate symbols with 50% valid / ready toggling
    vld_pct = 50;
    rdy_pct = 50;
    for (int s = 0; s < 20; s++) begin
      logic [3:0] code;
      int nb;
      code = rates[$urandom_range(7, 0)];
      nb   = ncbps_of(code) / 8;
      if ($urandom_range(4, 0) == 0)
        add_symbol(code, $urandom_range(nb - 1, 1), 1'b1, 1'b1);
      else
        add_symbol(code, nb, (s == 19) || ($urandom_range(3, 0) == 0), 1'b1);
    end
    drain(20000);

    check("total_out_bytes", out_count, exp_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
